ccff_chain_loader: RTL and testbench

- Configuration-chain driver sitting directly upstream of the logic tile's ccff_head input.
- Accepts bitstream words from the host over a valid/ready interface and serialises them LSB-first onto ccff_head, gating the chain's shift clock.
- After loading, rotates the chain once (ccff_tail fed back to ccff_head) and compares CRC-16 signatures of the bits shifted in and the bits read back.
- Leaves the chain contents intact and reports pass/fail.

---
 rtl/ccff_chain_loader_pkg.sv | 20 ++
 rtl/ccff_chain_loader_if.sv | 11 +
 rtl/ccff_crc16_serial.sv | 26 ++
 rtl/ccff_chain_loader.sv | 170 +++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and the bit-serial CRC-16-CCITT step used by the configuration-chain loader.
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // One bit of CRC-16-CCITT, message bits taken in the order they travel down the chain.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host-side bitstream word channel (valid/ready) into the configuration-chain loader.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master(output cfg_data, output cfg_valid, input cfg_ready);
  modport slave(input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16 accumulator with a synchronous clear back to the seed value.
module ccff_crc16_serial
  import ccff_chain_loader_pkg::*;
#(
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        prog_clk,
    input  logic        pReset,
    input  logic        enable,
    input  logic        bit_in,
    input  logic        clear,
    output logic [15:0] crc_out
);

  // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      crc_out <= CRC_INIT;
    end else if (clear) begin
      crc_out <= CRC_INIT;
    end else if (enable) begin
      crc_out <= crc16_step(crc_out, bit_in);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words LSB-first into a config chain, then rotates the chain once
// and compares shift-in and readback CRC-16 signatures.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
    parameter int          CHAIN_LEN = 21,
    parameter int          WORD_W    = 8,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic                     prog_clk,
    input  logic                     pReset,
    input  logic                     start,
    ccff_chain_loader_if.slave       cfg,
    output logic                     ccff_head,
    output logic                     chain_clk_en,
    input  logic                     ccff_tail,
    output logic                     busy,
    output logic                     done,
    output logic                     crc_err
);

  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int BCW       = $clog2(CHAIN_LEN + 1);
  localparam int WCW       = $clog2(NW + 1);
  localparam int SCW       = $clog2(WORD_W + 1);

  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic                head_q, head_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [SCW-1:0]      left_q, left_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [WCW-1:0]      wcnt_q, wcnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready;
  logic [15:0]         crc_in, crc_rb;
  logic                crc_mismatch;

  assign crc_mismatch = (crc_in != crc_rb);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    en_d    = en_q;
    head_d  = head_q;
    buf_d   = buf_q;
    left_d  = left_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    done_d  = done_q;
    err_d   = err_q;
    ready   = 1'b0;

    case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        bcnt_d = '0;
        wcnt_d = '0;
        left_d = '0;
        if (start) begin
          state_d = LOAD;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        // head_q is the bit being shifted this cycle; the buffer holds the ones after it.
        ready = (left_q == '0) && (wcnt_q < WCW'(NW));
        if (en_q && bcnt_q == BCW'(CHAIN_LEN - 1)) begin
          state_d = VERIFY;
          bcnt_d  = '0;
          en_d    = 1'b1;
        end else begin
          if (en_q) bcnt_d = bcnt_q + 1'b1;
          if (left_q != '0) begin
            head_d = buf_q[0];
            buf_d  = buf_q >> 1;
            left_d = left_q - 1'b1;
            en_d   = 1'b1;
          end else if (cfg.cfg_valid && ready) begin
            head_d = cfg.cfg_data[0];
            buf_d  = cfg.cfg_data >> 1;
            left_d = (wcnt_q == WCW'(NW - 1)) ? SCW'(LAST_BITS - 1) : SCW'(WORD_W - 1);
            wcnt_d = wcnt_q + 1'b1;
            en_d   = 1'b1;
          end else begin
            en_d = 1'b0;
          end
        end
      end

      VERIFY: begin
        if (bcnt_q == BCW'(CHAIN_LEN - 1)) begin
          state_d = DONE;
          bcnt_d  = '0;
          en_d    = 1'b0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
          en_d   = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = crc_mismatch;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      // NOTE: the word buffer is reset along with the counters so no X can ever reach ccff_head.
      en_q   <= 1'b0;
      head_q <= 1'b0;
      buf_q  <= '0;
      left_q <= '0;
      bcnt_q <= '0;
      wcnt_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      head_q <= head_d;
      buf_q  <= buf_d;
      left_q <= left_d;
      bcnt_q <= bcnt_d;
      wcnt_q <= wcnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  ccff_crc16_serial #(.CRC_INIT(CRC_INIT)) u_crc_shift_in (
      .prog_clk(prog_clk),
      .pReset  (pReset),
      .enable  ((state_q == LOAD) && en_q),
      .bit_in  (head_q),
      .clear   (state_q == IDLE),
      .crc_out (crc_in)
  );

  ccff_crc16_serial #(.CRC_INIT(CRC_INIT)) u_crc_readback (
      .prog_clk(prog_clk),
      .pReset  (pReset),
      .enable  (state_q == VERIFY),
      .bit_in  (ccff_tail),
      .clear   (state_q == IDLE),
      .crc_out (crc_rb)
  );

  // Rotation during VERIFY is the block's single combinational in-to-out path.
  assign ccff_head     = (state_q == VERIFY) ? ccff_tail : head_q;
  assign chain_clk_en  = en_q;
  assign cfg.cfg_ready = ready;
  assign busy          = (state_q == LOAD) || (state_q == VERIFY);
  assign done          = done_q || (state_q == DONE);
  assign crc_err       = (state_q == DONE) ? crc_mismatch : err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 21-flop chain model driven through a vector table,
// plus a CHAIN_LEN=1 instance for the single-bit corner.
module tb_ccff_chain_loader;

  localparam int CL    = 21;
  localparam int NW0   = 3;
  localparam int LAST0 = 5;

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          gap;
    bit          stuck;
    bit          restart;
    int          abort_bits;
    bit          exp_err;
    logic [20:0] exp_chain;
    int          exp_cycles;
    int          exp_stalls;
  } vec_t;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  logic start0   = 1'b0;
  logic start1   = 1'b0;

  ccff_chain_loader_if #(.WORD_W(8)) host0_if ();
  ccff_chain_loader_if #(.WORD_W(8)) host1_if ();

  logic ccff_head0, chain_clk_en0, ccff_tail0, busy0, done0, crc_err0;
  logic ccff_head1, chain_clk_en1, ccff_tail1, busy1, done1, crc_err1;

  logic [CL-1:0] chain0 = '0;
  logic          chain1 = 1'b1;
  bit            stuck0 = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8), .CRC_INIT(16'hFFFF)) dut0 (
      .prog_clk    (prog_clk),
      .pReset      (pReset),
      .start       (start0),
      .cfg         (host0_if),
      .ccff_head   (ccff_head0),
      .chain_clk_en(chain_clk_en0),
      .ccff_tail   (ccff_tail0),
      .busy        (busy0),
      .done        (done0),
      .crc_err     (crc_err0)
  );

  ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(8), .CRC_INIT(16'hFFFF)) dut1 (
      .prog_clk    (prog_clk),
      .pReset      (pReset),
      .start       (start1),
      .cfg         (host1_if),
      .ccff_head   (ccff_head1),
      .chain_clk_en(chain_clk_en1),
      .ccff_tail   (ccff_tail1),
      .busy        (busy1),
      .done        (done1),
      .crc_err     (crc_err1)
  );

  // Chain models: plain shift registers, optionally with flop 7 stuck at 0.
  always @(posedge prog_clk) begin
    if (chain_clk_en0)
      chain0 <= stuck0 ? ({chain0[CL-2:0], ccff_head0} & ~21'h000080) : {chain0[CL-2:0], ccff_head0};
    if (chain_clk_en1) chain1 <= ccff_head1;
  end
  assign ccff_tail0 = chain0[CL-1];
  assign ccff_tail1 = chain1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected chain after a clean load: first bit shifted ends up at the tail end.
  function automatic logic [20:0] model_chain(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0]  w[3];
    logic [20:0] v;
    w[0] = a; w[1] = b; w[2] = c;
    v = '0;
    for (int i = 0; i < CL; i++) v[CL-1-i] = w[i/8][i%8];
    return v;
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input int gap, input bit stuck, input bit restart, input int abort_bits,
                              input bit exp_err, input logic [20:0] exp_chain, input int exp_cycles,
                              input int exp_stalls);
    vec_t v;
    v.w0 = a; v.w1 = b; v.w2 = c;
    v.gap = gap; v.stuck = stuck; v.restart = restart; v.abort_bits = abort_bits;
    v.exp_err = exp_err; v.exp_chain = exp_chain; v.exp_cycles = exp_cycles; v.exp_stalls = exp_stalls;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [7:0] w[3];
    bit         q[$];
    int         wi = 0, gap_left = 0, shifts = 0, en_cyc = 0, stalls = 0;
    int         vready = 0, busy_bad = 0, done_cyc = -1, idle_bad = 0, nb;
    bit         restarted = 1'b0, exp_bit;

    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
    stuck0 = v.stuck;
    @(negedge prog_clk);
    start0 = 1'b1;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge prog_clk);
      start0 = 1'b0;

      if (v.abort_bits >= 0 && shifts == v.abort_bits) begin
        pReset = 1'b1;
        #1;
        check("abort_outputs_zero",
              {busy0, done0, crc_err0, chain_clk_en0, ccff_head0, host0_if.cfg_ready}, 0);
        host0_if.cfg_valid = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b0;
        return;
      end

      if (done0) begin
        done_cyc = cyc;
        break;
      end
      if (!busy0) busy_bad++;

      if (chain_clk_en0) begin
        en_cyc++;
        if (shifts < CL) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underrun: shift %0d with no expected bit queued", shifts);
          end else begin
            exp_bit = q.pop_front();
            check("load_bit", ccff_head0, exp_bit);
          end
          shifts++;
        end else begin
          if (host0_if.cfg_ready) vready++;
          if (v.restart && !restarted) begin
            start0    = 1'b1;
            restarted = 1'b1;
          end
        end
      end else if (shifts > 0 && shifts < CL) begin
        stalls++;
      end

      host0_if.cfg_valid = (wi < NW0) && (gap_left == 0);
      host0_if.cfg_data  = (wi < NW0) ? w[wi] : 8'h00;
      if (host0_if.cfg_valid && host0_if.cfg_ready) begin
        nb = (wi == NW0 - 1) ? LAST0 : 8;
        for (int b = 0; b < nb; b++) q.push_back(w[wi][b]);
        wi++;
        gap_left = v.gap;
      end else if (host0_if.cfg_ready && gap_left > 0) begin
        gap_left--;
      end
    end

    host0_if.cfg_valid = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within 300 cycles, required %0d", v.exp_cycles);
    end
    check("start_to_done", done_cyc, v.exp_cycles);
    check("busy_in_done", busy0, 0);
    check("crc_err", crc_err0, v.exp_err);
    check("chain_contents", chain0, v.exp_chain);
    check("shift_cycles", en_cyc, 2 * CL);
    check("stall_cycles", stalls, v.exp_stalls);
    check("ready_in_verify", vready, 0);
    check("busy_gaps", busy_bad, 0);
    check("sb_leftover", q.size(), 0);

    repeat (4) begin
      @(negedge prog_clk);
      if (busy0 || chain_clk_en0) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);
    check("done_sticky", done0, 1);
    check("err_sticky", crc_err0, v.exp_err);
    check("chain_retained", chain0, v.exp_chain);
  endtask

  initial begin
    vec_t vecs[6];
    int   hs, en1, done_cyc1, head_bad1;

    vecs[0] = mk(8'hA5, 8'h3C, 8'h1F, 0, 0, 0, -1, 0, model_chain(8'hA5, 8'h3C, 8'h1F), 44, 0);
    vecs[1] = mk(8'hA5, 8'h3C, 8'h1F, 3, 0, 0, -1, 0, model_chain(8'hA5, 8'h3C, 8'h1F), 50, 6);
    vecs[2] = mk(8'hFF, 8'hFF, 8'hFF, 0, 1, 0, -1, 1, 21'h000000, 44, 0);
    vecs[3] = mk(8'h5A, 8'hC3, 8'h0E, 0, 0, 0, 10, 0, 21'h000000, 0, 0);
    vecs[4] = mk(8'h5A, 8'hC3, 8'h0E, 0, 0, 0, -1, 0, model_chain(8'h5A, 8'hC3, 8'h0E), 44, 0);
    vecs[5] = mk(8'hA5, 8'h3C, 8'h1F, 0, 0, 1, -1, 0, model_chain(8'hA5, 8'h3C, 8'h1F), 44, 0);

    host0_if.cfg_valid = 1'b0;
    host0_if.cfg_data  = 8'h00;
    host1_if.cfg_valid = 1'b0;
    host1_if.cfg_data  = 8'h00;

    repeat (2) @(negedge prog_clk);
    check("reset_outputs",
          {busy0, done0, crc_err0, chain_clk_en0, ccff_head0, host0_if.cfg_ready}, 0);
    pReset = 1'b0;
    @(negedge prog_clk);
    check("idle_outputs",
          {busy0, done0, crc_err0, chain_clk_en0, ccff_head0, host0_if.cfg_ready}, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Single-flop chain: only bit 0 of 0xFE is shifted, valid stays high throughout.
    hs = 0; en1 = 0; done_cyc1 = -1; head_bad1 = 0;
    @(negedge prog_clk);
    start1 = 1'b1;
    for (int cyc = 1; cyc < 40; cyc++) begin
      @(negedge prog_clk);
      start1 = 1'b0;
      host1_if.cfg_valid = 1'b1;
      host1_if.cfg_data  = 8'hFE;
      if (done1) begin
        done_cyc1 = cyc;
        break;
      end
      if (chain_clk_en1) begin
        en1++;
        if (en1 == 1 && ccff_head1 !== 1'b0) head_bad1++;
      end
      if (host1_if.cfg_valid && host1_if.cfg_ready) hs++;
    end
    host1_if.cfg_valid = 1'b0;
    if (done_cyc1 < 0) begin
      checks++;
      failures++;
      $display("FAIL len1_timeout: no done within 40 cycles, required 4");
    end
    check("len1_handshakes", hs, 1);
    check("len1_shift_cycles", en1, 2);
    check("len1_head_bit", head_bad1, 0);
    check("len1_start_to_done", done_cyc1, 4);
    check("len1_crc_err", crc_err1, 0);
    check("len1_chain", chain1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
